render_frame_sequencer: RTL and testbench

RENDER_FRAME_SEQUENCER -- requirements
Module: render_frame_sequencer

---
 rtl/render_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_render_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/render_frame_sequencer.sv
// Frame sequencer: clears and draws into a back buffer, then swaps
// it to the display on vsync (double or triple buffered).
module render_frame_sequencer #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int NUM_BUF  = 2,
  parameter int CLEAR_EN = 1,
  parameter int FC_W     = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            run,
  input  logic            vsync_pulse,
  input  logic            draw_done,
  output logic            draw_start,
  output logic            clear_we,
  output logic [9:0]      ClearX,
  output logic [9:0]      ClearY,
  output logic [1:0]      draw_buf,
  output logic [1:0]      disp_buf,
  output logic            busy,
  output logic            frame_done,
  output logic [FC_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAW,
    WAIT_SYNC
  } state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
  localparam bit CLR = (CLEAR_EN != 0);
  localparam bit TRI = (NUM_BUF == 3);

  state_t     state;
  logic [1:0] ready_buf;
  logic       ready_valid;
  logic       vs_swap;
  logic [1:0] disp_eff;
  logic [1:0] free_buf;

  // Early swap of a ready frame outside WAIT_SYNC
  assign vs_swap = TRI && vsync_pulse && ready_valid
                   && (state != WAIT_SYNC);
  assign disp_eff = vs_swap ? ready_buf : disp_buf;
  assign free_buf = 2'd3 - disp_eff - draw_buf;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      disp_buf    <= 2'd0;
      draw_buf    <= 2'd1;
      ready_buf   <= 2'd2;
      ready_valid <= 1'b0;
      frame_count <= '0;
      ClearX      <= '0;
      ClearY      <= '0;
      clear_we    <= 1'b0;
      draw_start  <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      draw_start <= 1'b0;
      frame_done <= 1'b0;
      if (vs_swap) begin
        disp_buf    <= ready_buf;
        ready_valid <= 1'b0;
        frame_done  <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (run) begin
            state      <= CLR ? CLEAR : DRAW;
            clear_we   <= CLR;
            draw_start <= !CLR;
            busy       <= 1'b1;
          end
        end
        CLEAR: begin
          if (ClearX == X_LAST && ClearY == Y_LAST) begin
            state      <= DRAW;
            clear_we   <= 1'b0;
            ClearX     <= '0;
            ClearY     <= '0;
            draw_start <= 1'b1;
          end else if (ClearX == X_LAST) begin
            ClearX <= '0;
            ClearY <= ClearY + 10'd1;
          end else begin
            ClearX <= ClearX + 10'd1;
          end
        end
        DRAW: begin
          if (!draw_start && draw_done) begin
            if (!TRI || (ready_valid && !vs_swap)) begin
              state <= WAIT_SYNC;
            end else begin
              ready_buf   <= draw_buf;
              ready_valid <= 1'b1;
              draw_buf    <= free_buf;
              if (run) begin
                state      <= CLR ? CLEAR : DRAW;
                clear_we   <= CLR;
                draw_start <= !CLR;
              end else begin
                state <= WAIT_SYNC;
              end
            end
          end
        end
        WAIT_SYNC: begin
          if (vsync_pulse) begin
            if (TRI && ready_valid) begin
              disp_buf  <= ready_buf;
              ready_buf <= draw_buf;
            end else begin
              disp_buf <= draw_buf;
            end
            draw_buf    <= disp_buf;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            if (run) begin
              state      <= CLR ? CLEAR : DRAW;
              clear_we   <= CLR;
              draw_start <= !CLR;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Directed bench: double, triple and no-clear sequencer instances
// with hand-computed buffer, strobe and counter expectations.
module tb_render_frame_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic a_run = 0, a_vs = 0, a_dd = 0;
  logic a_ds, a_cw, a_busy, a_fd;
  logic [9:0] a_x, a_y;
  logic [1:0] a_draw, a_disp;
  logic [7:0] a_fc;

  logic b_run = 0, b_vs = 0, b_dd = 0;
  logic b_ds, b_cw, b_busy, b_fd;
  logic [9:0] b_x, b_y;
  logic [1:0] b_draw, b_disp;
  logic [7:0] b_fc;

  logic c_run = 0, c_vs = 0, c_dd = 0;
  logic c_ds, c_cw, c_busy, c_fd;
  logic [9:0] c_x, c_y;
  logic [1:0] c_draw, c_disp;
  logic [1:0] c_fc;
  logic c_cw_seen = 0;

  int n_tests = 0;
  int n_fail = 0;

  render_frame_sequencer #(
    .H_RES(4), .V_RES(2), .NUM_BUF(2), .CLEAR_EN(1), .FC_W(8)
  ) u_a (
    .Clk(Clk), .Reset(Reset), .run(a_run),
    .vsync_pulse(a_vs), .draw_done(a_dd),
    .draw_start(a_ds), .clear_we(a_cw),
    .ClearX(a_x), .ClearY(a_y),
    .draw_buf(a_draw), .disp_buf(a_disp),
    .busy(a_busy), .frame_done(a_fd), .frame_count(a_fc)
  );

  render_frame_sequencer #(
    .H_RES(4), .V_RES(2), .NUM_BUF(3), .CLEAR_EN(1), .FC_W(8)
  ) u_b (
    .Clk(Clk), .Reset(Reset), .run(b_run),
    .vsync_pulse(b_vs), .draw_done(b_dd),
    .draw_start(b_ds), .clear_we(b_cw),
    .ClearX(b_x), .ClearY(b_y),
    .draw_buf(b_draw), .disp_buf(b_disp),
    .busy(b_busy), .frame_done(b_fd), .frame_count(b_fc)
  );

  render_frame_sequencer #(
    .H_RES(4), .V_RES(2), .NUM_BUF(2), .CLEAR_EN(0), .FC_W(2)
  ) u_c (
    .Clk(Clk), .Reset(Reset), .run(c_run),
    .vsync_pulse(c_vs), .draw_done(c_dd),
    .draw_start(c_ds), .clear_we(c_cw),
    .ClearX(c_x), .ClearY(c_y),
    .draw_buf(c_draw), .disp_buf(c_disp),
    .busy(c_busy), .frame_done(c_fd), .frame_count(c_fc)
  );

  always @(negedge Clk) if (c_cw) c_cw_seen <= 1'b1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_start(input int sel);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      seen = (sel == 0) ? a_ds : (sel == 1) ? b_ds : c_ds;
      if (!seen) step();
    end
    check("wait_start", 32'(seen), 1);
  endtask

  initial begin
    // Reset values
    step();
    step();
    check("rst_busy", a_busy, 0);
    check("rst_disp", a_disp, 0);
    check("rst_draw", a_draw, 1);
    check("rst_cw", a_cw, 0);
    check("rst_fc", a_fc, 0);
    check("rst_x", a_x, 0);
    check("rst_b_draw", b_draw, 1);

    // Double buffer: clear raster, draw, swap
    Reset = 0;
    a_run = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("clr_we", a_cw, 1);
      check("clr_x", a_x, 32'(i % 4));
      check("clr_y", a_y, 32'(i / 4));
      step();
    end
    check("ds_pulse", a_ds, 1);
    check("ds_cw", a_cw, 0);
    check("ds_x", a_x, 0);
    check("ds_busy", a_busy, 1);
    a_dd = 1;
    step();
    a_dd = 0;
    a_vs = 1;
    step();
    a_vs = 0;
    check("dd_ignored_fd", a_fd, 0);
    check("dd_ignored_fc", a_fc, 0);
    check("ds_once", a_ds, 0);
    a_dd = 1;
    step();
    a_dd = 0;
    a_vs = 1;
    step();
    a_vs = 0;
    check("swap_fd", a_fd, 1);
    check("swap_disp", a_disp, 1);
    check("swap_draw", a_draw, 0);
    check("swap_fc", a_fc, 1);
    check("swap_clr", a_cw, 1);
    a_run = 0;
    step();
    check("fd_once", a_fd, 0);
    check("run_low_clr", a_cw, 1);
    wait_start(0);
    step();
    a_dd = 1;
    step();
    a_dd = 0;
    a_vs = 1;
    step();
    a_vs = 0;
    check("swap2_fd", a_fd, 1);
    check("swap2_disp", a_disp, 0);
    check("swap2_draw", a_draw, 1);
    check("swap2_fc", a_fc, 2);
    check("swap2_idle", a_busy, 0);
    step();
    check("idle_busy", a_busy, 0);
    check("idle_cw", a_cw, 0);

    // Reset during clear at pixel 5
    Reset = 1;
    step();
    Reset = 0;
    a_run = 1;
    step();
    for (int i = 0; i < 5; i++) step();
    check("pix5_x", a_x, 1);
    check("pix5_y", a_y, 1);
    Reset = 1;
    step();
    Reset = 0;
    a_run = 0;
    check("abort_cw", a_cw, 0);
    check("abort_x", a_x, 0);
    check("abort_y", a_y, 0);
    check("abort_disp", a_disp, 0);
    check("abort_draw", a_draw, 1);
    check("abort_busy", a_busy, 0);
    a_vs = 1;
    step();
    a_vs = 0;
    check("idle_vs_fd", a_fd, 0);

    // Triple buffer
    b_run = 1;
    wait_start(1);
    step();
    b_dd = 1;
    step();
    b_dd = 0;
    check("tri_draw", b_draw, 2);
    check("tri_disp", b_disp, 0);
    check("tri_clr", b_cw, 1);
    check("tri_fd0", b_fd, 0);
    b_vs = 1;
    step();
    b_vs = 0;
    check("tri_vs_disp", b_disp, 1);
    check("tri_vs_fd", b_fd, 1);
    check("tri_vs_fc", b_fc, 1);
    check("tri_vs_draw", b_draw, 2);
    wait_start(1);
    step();
    b_dd = 1;
    step();
    b_dd = 0;
    check("tri2_draw", b_draw, 0);
    check("tri2_disp", b_disp, 1);
    wait_start(1);
    step();
    b_dd = 1;
    b_vs = 1;
    step();
    b_dd = 0;
    b_vs = 0;
    check("both_disp", b_disp, 2);
    check("both_draw", b_draw, 1);
    check("both_fd", b_fd, 1);
    check("both_fc", b_fc, 2);
    step();
    check("both_fd_once", b_fd, 0);
    b_vs = 1;
    step();
    b_vs = 0;
    check("early_disp", b_disp, 0);
    check("early_fc", b_fc, 3);
    check("early_fd", b_fd, 1);

    // No clear pass, 2-bit frame counter wraps
    c_run = 1;
    for (int f = 0; f < 5; f++) begin
      wait_start(2);
      step();
      c_dd = 1;
      step();
      c_dd = 0;
      c_vs = 1;
      step();
      c_vs = 0;
      check("nc_fd", c_fd, 1);
      check("nc_fc", c_fc, 32'((f + 1) % 4));
    end
    step();
    check("nc_no_clear", 32'(c_cw_seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
